// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester ids, funct3 codes.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    ID_CORE = 1'b0,
    ID_DBG  = 1'b1
  } req_id_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // 0 = byte, 1 = halfword, 2 = word; unlisted codes fall back to word
  function automatic logic [1:0] f3_size(input logic [2:0] f3);
    if (f3 == F3_B || f3 == F3_BU) return 2'd0;
    else if (f3 == F3_H || f3 == F3_HU) return 2'd1;
    else return 2'd2;
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: store byte enables and data replication, load
// extraction with sign/zero extension, and misalignment detection. Purely combinational.
module dmem_lane_fmt
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              we,
  input  logic [1:0]        lane,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata_rep,
  output logic [DATA_W-1:0] rdata,
  output logic              misaligned
);

  logic [1:0]        size;
  logic              zext;
  logic [DATA_W-1:0] shifted;

  always_comb begin
    size       = f3_size(funct3);
    zext       = (funct3 == F3_BU) || (funct3 == F3_HU);
    shifted    = mem_rdata >> {lane, 3'b000};
    be         = 4'b0000;
    wdata_rep  = wdata;
    rdata      = '0;
    misaligned = 1'b0;
    case (size)
      2'd0: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = zext ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        misaligned = lane[0];
        be         = 4'b0011 << lane;
        wdata_rep  = {2{wdata[15:0]}};
        rdata      = zext ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: begin
        misaligned = |lane;
        be         = 4'b1111;
        wdata_rep  = wdata;
        rdata      = mem_rdata;
      end
    endcase
    if (misaligned) begin
      be    = 4'b0000;
      rdata = '0;
    end
    if (we) rdata = '0;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: one access per three cycles (gnt, access, response).
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed core priority.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_funct3,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_err,

  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  input  logic [2:0]            dbg_funct3,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  dbg_err,

  output logic [DM_ADDRESS-3:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [3:0]            mem_be,
  output logic                  mem_we,
  input  logic [DATA_W-1:0]     mem_rdata
);

  state_t                state_q, state_d;
  logic                  lat_we;
  logic [DM_ADDRESS-1:0] lat_addr;
  logic [DATA_W-1:0]     lat_wdata;
  logic [2:0]            lat_f3;
  req_id_t               lat_id;

  logic                  any_req;
  logic                  win_dbg;
  logic                  accept;
  logic                  in_access;
  logic                  in_resp;

  logic [3:0]            fmt_be;
  logic [DATA_W-1:0]     fmt_wdata;
  logic [DATA_W-1:0]     fmt_rdata;
  logic                  fmt_mis;

  assign any_req = core_req | dbg_req;

`ifdef DMEM_ARB_RR_EN
  // last_dbg starts set so the first tie goes to core
  logic last_dbg;

  always_ff @(posedge clk) begin
    if (!rst_n) last_dbg <= 1'b1;
    else if (accept) last_dbg <= win_dbg;
  end

  assign win_dbg = dbg_req & (~core_req | ~last_dbg);
`else
  assign win_dbg = dbg_req & ~core_req;
`endif

  assign accept = rst_n & (state_q == ST_IDLE) & any_req;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (any_req) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_f3    <= 3'b000;
      lat_id    <= ID_CORE;
    end else if (accept) begin
      lat_we    <= win_dbg ? dbg_we     : core_we;
      lat_addr  <= win_dbg ? dbg_addr   : core_addr;
      lat_wdata <= win_dbg ? dbg_wdata  : core_wdata;
      lat_f3    <= win_dbg ? dbg_funct3 : core_funct3;
      lat_id    <= win_dbg ? ID_DBG     : ID_CORE;
    end
  end

  dmem_lane_fmt #(.DATA_W(DATA_W)) u_fmt (
    .we         (lat_we),
    .lane       (lat_addr[1:0]),
    .funct3     (lat_f3),
    .wdata      (lat_wdata),
    .mem_rdata  (mem_rdata),
    .be         (fmt_be),
    .wdata_rep  (fmt_wdata),
    .rdata      (fmt_rdata),
    .misaligned (fmt_mis)
  );

  // Outputs are qualified by rst_n so an access caught by reset never writes or responds
  always_comb begin
    in_access   = rst_n & (state_q == ST_ACCESS);
    in_resp     = rst_n & (state_q == ST_RESP);
    core_gnt    = accept & ~win_dbg;
    dbg_gnt     = accept & win_dbg;
    mem_addr    = lat_addr[DM_ADDRESS-1:2];
    mem_wdata   = fmt_wdata;
    mem_we      = in_access & lat_we & ~fmt_mis;
    mem_be      = mem_we ? fmt_be : 4'b0000;
    core_rvalid = in_resp & (lat_id == ID_CORE);
    dbg_rvalid  = in_resp & (lat_id == ID_DBG);
    core_err    = core_rvalid & fmt_mis;
    dbg_err     = dbg_rvalid & fmt_mis;
    core_rdata  = core_rvalid ? fmt_rdata : '0;
    dbg_rdata   = dbg_rvalid ? fmt_rdata : '0;
  end

endmodule
